stream_accumulator: RTL and testbench



---
 rtl/stream_accumulator_if.sv | 32 +++
 rtl/stream_accumulator.sv | 91 +++++++++
 tb/tb_stream_accumulator.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/stream_accumulator_if.sv
// Stream bundle for the block accumulator: an operand stream in and a
// widened result stream out. The environment (producer and consumer) drives
// through the master modport; the accumulator connects through the slave one.
interface stream_accumulator_if #(
  parameter int WIDTH     = 8,
  parameter int OUT_WIDTH = 10
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/stream_accumulator.sv
// Unsigned block accumulator: sums every COUNT accepted operands into one
// width-grown result held in a single-entry output register. Full throughput
// is kept by loading a new result in the same cycle the old one drains.
module stream_accumulator #(
  parameter int  WIDTH     = 8,
  parameter int  COUNT     = 4,
  localparam int OUT_WIDTH = WIDTH + $clog2(COUNT)
) (
  input logic                 clk,
  input logic                 rst_n,
  stream_accumulator_if.slave bus
);

  // COUNT == 1 still gets a 1-bit counter; it simply stays at zero.
  localparam int              CNT_W    = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic [OUT_WIDTH-1:0] operand;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 out_valid_q, out_valid_d;
  logic                 is_last;
  logic                 in_ready;
  logic                 in_fire;
  logic                 out_fire;

  assign operand  = OUT_WIDTH'(bus.in_data);
  assign is_last  = (cnt_q == CNT_LAST);
  // Only the block-completing operand needs the output slot, so only it
  // can be held off; the out_ready term makes drain-and-refill a single cycle.
  assign in_ready = !(is_last && out_valid_q && !bus.out_ready);
  assign in_fire  = bus.in_valid && in_ready;
  assign out_fire = out_valid_q && bus.out_ready;

  // Next-state: running sum, block position and the output slot.
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    if (out_fire) begin
      out_valid_d = 1'b0;
    end

    if (in_fire) begin
      if (is_last) begin
        out_data_d  = acc_q + operand;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
      end else begin
        acc_d = acc_q + operand;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers; reset drops any partial block and any pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  // A stalled result must stay put until the consumer takes it.
  a_stall_stable : assert property (
    @(posedge clk) disable iff (!rst_n)
    (out_valid_q && !bus.out_ready) |=> (out_valid_q && $stable(out_data_q))
  );

  // Backpressure only ever appears at a block boundary.
  a_ready_only_at_last : assert property (
    @(posedge clk) disable iff (!rst_n)
    !in_ready |-> is_last
  );

endmodule

// File: tb/tb_stream_accumulator.sv
// Bench for stream_accumulator: a COUNT=4 and a COUNT=1 instance share the
// input stream; a block-sum reference model with a result queue checks
// in_ready, out_valid and out_data every cycle, plus directed spot checks.
module tb_stream_accumulator;

  logic clk;
  logic rst_n;

  stream_accumulator_if #(.WIDTH(8), .OUT_WIDTH(10)) bus  ();
  stream_accumulator_if #(.WIDTH(8), .OUT_WIDTH(8))  bus1 ();

  stream_accumulator #(.WIDTH(8), .COUNT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  stream_accumulator #(.WIDTH(8), .COUNT(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: block sums of accepted operands, one queue per instance.
  int          blk_len [2] = '{4, 1};
  int unsigned blk_sum [2];
  int          blk_n   [2];
  int unsigned expq    [2][$];

  task automatic model_clear();
    for (int m = 0; m < 2; m++) begin
      blk_sum[m] = 0;
      blk_n[m]   = 0;
      expq[m].delete();
    end
  endtask

  always @(negedge clk) begin
    bit          iv, ir, ov, ordy, exp_ir, pending;
    int unsigned id, od;
    for (int m = 0; m < 2; m++) begin
      if (m == 0) begin
        iv = bus.in_valid;  ir = bus.in_ready;  ov = bus.out_valid;
        ordy = bus.out_ready;  id = bus.in_data;  od = bus.out_data;
      end else begin
        iv = bus1.in_valid; ir = bus1.in_ready; ov = bus1.out_valid;
        ordy = bus1.out_ready; id = bus1.in_data; od = bus1.out_data;
      end
      pending = (expq[m].size() != 0);
      exp_ir  = !((blk_n[m] == blk_len[m] - 1) && pending && !ordy);
      check_eq((m == 0) ? "in_ready_c4"  : "in_ready_c1",  ir, exp_ir);
      check_eq((m == 0) ? "out_valid_c4" : "out_valid_c1", ov, pending);
      if (pending) begin
        check_eq((m == 0) ? "out_data_c4" : "out_data_c1", od, expq[m][0]);
        if (ordy) void'(expq[m].pop_front());
      end
      if (iv && exp_ir) begin
        blk_sum[m] += id;
        blk_n[m]++;
        if (blk_n[m] == blk_len[m]) begin
          expq[m].push_back(blk_sum[m]);
          blk_sum[m] = 0;
          blk_n[m]   = 0;
        end
      end
    end
  end

  // Apply one cycle of stimulus to both instances and step past the edge.
  task automatic drive(input bit iv, input int d, input bit o0, input bit o1);
    bus.in_valid   = iv;
    bus.in_data    = d[7:0];
    bus.out_ready  = o0;
    bus1.in_valid  = iv;
    bus1.in_data   = d[7:0];
    bus1.out_ready = o1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_clear();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;  bus.in_data = '0;  bus.out_ready = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset mid-block: two accepts, then asynchronous reset.
    drive(1, 1, 1, 1);
    drive(1, 1, 1, 1);
    rst_n = 1'b0;
    model_clear();
    #1;
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_out_data",  bus.out_data, 0);
    check_eq("rst_in_ready",  bus.in_ready, 1);
    drive(0, 0, 1, 1);
    drive(0, 0, 1, 1);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) drive(1, 1, 1, 1);
    check_eq("rst_new_block", bus.out_data, 4);

    // Maximum operands: no overflow, one-cycle valid pulse.
    for (int i = 0; i < 4; i++) drive(1, 255, 1, 1);
    check_eq("max_sum",   bus.out_data, 1020);
    check_eq("max_valid", bus.out_valid, 1);
    drive(0, 0, 1, 1);
    check_eq("max_pulse", bus.out_valid, 0);

    // Full throughput, 1..12.
    for (int i = 1; i <= 12; i++) begin
      drive(1, i, 1, 1);
      if (i == 4)  check_eq("tput_r0", bus.out_data, 10);
      if (i == 8)  check_eq("tput_r1", bus.out_data, 26);
      if (i == 12) check_eq("tput_r2", bus.out_data, 42);
    end
    drive(0, 0, 1, 1);

    // Backpressure at the block boundary.
    for (int i = 1; i <= 4; i++) drive(1, i, 1, 1);
    drive(1, 5, 0, 1);
    drive(1, 6, 0, 1);
    drive(1, 7, 0, 1);
    bus.in_valid = 1'b1;  bus.in_data = 8'd8;  bus.out_ready = 1'b0;
    bus1.in_valid = 1'b0;
    #1;
    check_eq("bp_ready_low", bus.in_ready, 0);
    check_eq("bp_hold",      bus.out_data, 10);
    @(posedge clk);
    #1;
    check_eq("bp_ready_low2", bus.in_ready, 0);
    check_eq("bp_hold2",      bus.out_data, 10);
    bus.out_ready = 1'b1;
    #1;
    check_eq("bp_ready_comb", bus.in_ready, 1);
    @(posedge clk);
    #1;
    check_eq("bp_no_bubble", bus.out_valid, 1);
    check_eq("bp_next_sum",  bus.out_data, 26);
    drive(0, 0, 1, 1);

    // Gapped input.
    drive(1, 3, 1, 1);
    drive(0, 0, 1, 1);
    drive(0, 0, 1, 1);
    drive(1, 4, 1, 1);
    drive(0, 0, 1, 1);
    drive(1, 5, 1, 1);
    drive(1, 6, 1, 1);
    check_eq("gap_sum", bus.out_data, 18);
    drive(0, 0, 1, 1);

    // COUNT=1 instance: 7, 9 with out_ready 1,0,1.
    drive(1, 7, 1, 1);
    check_eq("c1_first", bus1.out_data, 7);
    bus.in_valid = 1'b0;
    bus1.in_valid = 1'b1; bus1.in_data = 8'd9; bus1.out_ready = 1'b0;
    #1;
    check_eq("c1_ready_low", bus1.in_ready, 0);
    @(posedge clk);
    #1;
    check_eq("c1_hold", bus1.out_data, 7);
    bus1.out_ready = 1'b1;
    #1;
    check_eq("c1_ready_back", bus1.in_ready, 1);
    @(posedge clk);
    #1;
    check_eq("c1_second", bus1.out_data, 9);
    drive(0, 0, 1, 1);

    // Randomized traffic with independent backpressure and one reset.
    for (int c = 0; c < 800; c++) begin
      if (c == 400) begin
        rst_n = 1'b0;
        model_clear();
        drive(0, 0, 1, 1);
        rst_n = 1'b1;
      end
      drive(($urandom % 4) != 0, $urandom_range(0, 255),
            ($urandom % 3) != 0, ($urandom % 2) != 0);
    end
    drive(0, 0, 1, 1);
    drive(0, 0, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
